// File: rtl/serial_word_deserializer_pkg.sv
// Shared definitions for the serial word deserializer: FSM encodings and frame constants.
package serial_word_deserializer_pkg;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_DATA = 1'b1
    } ser_state_e;

    localparam logic FRAME_START_BIT = 1'b1;

endpackage

// File: rtl/serial_word_deserializer_frame_counter.sv
// Modulo-WIDTH data-bit counter, advancing only on enabled cycles; flags the final data bit.
module ser_frame_counter
    import serial_word_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic last_bit_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;

    assign last_bit_o = (cnt_q == CNT_LAST);

    // Wraps to zero on the last bit, so IDLE always sees a cleared counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= last_bit_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Frames a start-bit-prefixed serial stream into WIDTH-bit words behind a one-deep valid/ready buffer.
module serial_word_deserializer
    import serial_word_deserializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_en,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun
);

    ser_state_e       state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             busy_q;
    logic             overrun_q;
    logic             cnt_en;
    logic             last_bit;
    logic             done;
    logic             drop;

    assign cnt_en = ser_en & (state_q == SER_DATA);
    assign done   = cnt_en & last_bit;
    assign drop   = done & valid_q & ~word_ready;

    ser_frame_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (cnt_en),
        .last_bit_o (last_bit)
    );

    // After WIDTH shifts the first data bit has landed at bit 0 (LSB_FIRST) or bit WIDTH-1.
    always_comb begin
        shift_d = shift_q;
        if (LSB_FIRST) begin
            shift_d = {ser_in, shift_q[WIDTH-1:1]};
        end else begin
            shift_d = {shift_q[WIDTH-2:0], ser_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SER_IDLE;
            shift_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (ser_en) begin
                case (state_q)
                    SER_IDLE: begin
                        if (ser_in == FRAME_START_BIT) begin
                            state_q <= SER_DATA;
                            busy_q  <= 1'b1;
                        end
                    end
                    SER_DATA: begin
                        shift_q <= shift_d;
                        if (last_bit) begin
                            state_q <= SER_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= SER_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end

            if (done && !drop) begin
                word_q  <= shift_d;
                valid_q <= 1'b1;
            end else if (!done && valid_q && word_ready) begin
                valid_q <= 1'b0;
            end

            // A drop on the same edge as a clear request leaves overrun set.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench: LSB-first and MSB-first instances share one stimulus stream.
module tb_serial_word_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_en = 1'b0;
    logic       word_ready = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [7:0] wl, wm;
    logic       vl, vm, bl, bm, ol, om;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_word_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_en(ser_en),
        .word_out(wl), .word_valid(vl), .word_ready(word_ready),
        .busy(bl), .overrun(ol), .clr_overrun(clr_overrun)
    );

    serial_word_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_en(ser_en),
        .word_out(wm), .word_valid(vm), .word_ready(word_ready),
        .busy(bm), .overrun(om), .clr_overrun(clr_overrun)
    );

    typedef struct {
        logic [7:0] bits;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_en = 1'b1;
        ser_in = b;
        step();
    endtask

    // bits[0] is sent first; optional ready/clear on the final data-bit edge.
    task automatic send_frame(input logic [7:0] bits, input bit ready_last, input bit clr_last);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                if (ready_last) word_ready = 1'b1;
                if (clr_last) clr_overrun = 1'b1;
            end
            send_bit(bits[i]);
        end
        ser_en = 1'b0;
        ser_in = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic chk_state(input string nm, input logic [7:0] el, input logic [7:0] em,
                             input logic v, input logic b, input logic o);
        chk({nm, ".word_l"}, wl, el);
        chk({nm, ".word_m"}, wm, em);
        chk({nm, ".valid_l"}, vl, v);
        chk({nm, ".valid_m"}, vm, v);
        chk({nm, ".busy_l"}, bl, b);
        chk({nm, ".busy_m"}, bm, b);
        chk({nm, ".ovr_l"}, ol, o);
        chk({nm, ".ovr_m"}, om, o);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[1] = '{8'h01, 8'h01, 8'h80};
        vecs[2] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{8'h00, 8'h00, 8'h00};
        vecs[5] = '{8'hC1, 8'hC1, 8'h83};
        vecs[6] = '{8'h5A, 8'h5A, 8'h5A};

        #2;
        chk_state("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Line idle (ser_in=0) and disabled start bits must not open a frame.
        ser_en = 1'b1; ser_in = 1'b0; step();
        chk("idle_zero.busy", bl, 1'b0);
        ser_en = 1'b0; ser_in = 1'b1; step();
        chk("idle_dis.busy", bl, 1'b0);

        foreach (vecs[k]) begin
            word_ready = 1'b0;
            send_frame(vecs[k].bits, 1'b0, 1'b0);
            chk_state($sformatf("vec%0d", k), vecs[k].exp_lsb, vecs[k].exp_msb, 1'b1, 1'b0, 1'b0);
            word_ready = 1'b1;
            step();
            word_ready = 1'b0;
            chk_state($sformatf("vec%0d_pop", k), vecs[k].exp_lsb, vecs[k].exp_msb, 1'b0, 1'b0, 1'b0);
        end

        // ser_en toggling 1,0 with inverted garbage on disabled cycles.
        send_bit(1'b1);
        chk("gap.start_busy", bl, 1'b1);
        for (int i = 0; i < 8; i++) begin
            ser_en = 1'b0; ser_in = 1'b1; step();
            chk($sformatf("gap.frozen%0d", i), bl, 1'b1);
            send_bit(vecs[2].bits[i]);
            ser_in = ~vecs[2].bits[i];
        end
        ser_en = 1'b0;
        step();
        chk_state("gap", 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
        word_ready = 1'b1; step(); word_ready = 1'b0;

        // Held word plus new completion with no ready: drop and flag overrun.
        send_frame(8'h11, 1'b0, 1'b0);
        chk_state("ovr_first", 8'h11, 8'h88, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        chk_state("ovr_drop", 8'h11, 8'h88, 1'b1, 1'b0, 1'b1);
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk_state("ovr_clr", 8'h11, 8'h88, 1'b1, 1'b0, 1'b0);

        // Handshake on the completing edge replaces the held word.
        send_frame(8'h22, 1'b1, 1'b0);
        word_ready = 1'b0;
        chk_state("same_edge", 8'h22, 8'h44, 1'b1, 1'b0, 1'b0);

        // Set beats clear on the same edge.
        send_frame(8'h33, 1'b0, 1'b1);
        chk_state("set_beats_clr", 8'h22, 8'h44, 1'b1, 1'b0, 1'b1);

        // Async reset after four data bits of a frame.
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(vecs[6].bits[i]);
        chk("pre_rst.busy", bl, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_state("mid_rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        ser_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send_frame(8'h5A, 1'b0, 1'b0);
        chk_state("post_rst", 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0);

        // Back-to-back frames with the consumer always ready.
        word_ready = 1'b1;
        step();
        send_frame(8'hA5, 1'b0, 1'b0);
        chk_state("b2b_first", 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC1, 1'b0, 1'b0);
        chk_state("b2b_second", 8'hC1, 8'h83, 1'b1, 1'b0, 1'b0);
        step();
        chk("b2b_drain.valid", vl, 1'b0);
        word_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
